// File: rtl/coklu_bitlik_seri_toplayici_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package coklu_bitlik_seri_toplayici_pkg;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    TOPLA = 2'd1,
    SONUC = 2'd2
  } durum_t;

  localparam logic TOPLA_MOD = 1'b0;
  localparam logic CIKAR_MOD = 1'b1;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/coklu_bitlik_seri_toplayici_fulladder_zincir.sv
// DIGIT-bit combinational ripple chain of one-bit full adders; co_msb_in is
// the carry entering the top bit, used for signed-overflow detection.
module fulladder_zincir #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             co_msb_in
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign co        = c_s[DIGIT];
  assign co_msb_in = c_s[DIGIT-1];

endmodule

// File: rtl/coklu_bitlik_seri_toplayici.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, start/ready/valid framed.
// Optional Tasma (signed overflow) output is enabled by defining SERI_TOPLAYICI_TASMA_EN.
module coklu_bitlik_seri_toplayici
  import coklu_bitlik_seri_toplayici_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Basla,
  input  logic             Cikar,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Hazir,
  output logic             Gecerli,
  output logic [WIDTH:0]   Cikis
`ifdef SERI_TOPLAYICI_TASMA_EN
  ,
  output logic             Tasma
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  durum_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   cikis_q, cikis_d;

  logic [DIGIT-1:0] fa_s;
  logic             fa_co;
  logic             fa_co_msb_in;
  logic [WIDTH-1:0] sum_shift_s;

  fulladder_zincir #(.DIGIT(DIGIT)) u_zincir (
    .a         (a_q[DIGIT-1:0]),
    .b         (b_q[DIGIT-1:0]),
    .ci        (carry_q),
    .s         (fa_s),
    .co        (fa_co),
    .co_msb_in (fa_co_msb_in)
  );

  // New sum digit enters from the top so after N digits the LSB digit sits at bit 0.
  assign sum_shift_s = (sum_q >> DIGIT) | (WIDTH'(fa_s) << (WIDTH - DIGIT));

`ifdef SERI_TOPLAYICI_TASMA_EN
  logic tasma_q, tasma_d;
`else
  logic tasma_unused_s;
  assign tasma_unused_s = fa_co_msb_in;
`endif

  // Next-state and datapath update for the BOS/TOPLA/SONUC sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cikis_d = cikis_q;
`ifdef SERI_TOPLAYICI_TASMA_EN
    tasma_d = tasma_q;
`endif
    case (state_q)
      BOS: begin
        if (Basla) begin
          a_d     = A;
          b_d     = (Cikar == CIKAR_MOD) ? ~B : B;
          carry_d = (Cikar == TOPLA_MOD) ? 1'b0 : 1'b1;
          cnt_d   = '0;
          state_d = TOPLA;
        end else begin
          state_d = BOS;
        end
      end
      TOPLA: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift_s;
        carry_d = fa_co;
        if (cnt_q == CW'(N - 1)) begin
          cikis_d = {fa_co, sum_shift_s};
`ifdef SERI_TOPLAYICI_TASMA_EN
          tasma_d = fa_co ^ fa_co_msb_in;
`endif
          state_d = SONUC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SONUC: begin
        state_d = BOS;
      end
      default: begin
        state_d = BOS;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOS;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cikis_q <= '0;
`ifdef SERI_TOPLAYICI_TASMA_EN
      tasma_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cikis_q <= cikis_d;
`ifdef SERI_TOPLAYICI_TASMA_EN
      tasma_q <= tasma_d;
`endif
    end
  end

  assign Hazir   = (state_q == BOS);
  assign Gecerli = (state_q == SONUC);
  assign Cikis   = cikis_q;
`ifdef SERI_TOPLAYICI_TASMA_EN
  assign Tasma   = tasma_q;
`endif

endmodule

// File: tb/tb_coklu_bitlik_seri_toplayici.sv
// Scoreboard bench: three instances (8/1, 8/2, 16/4) checked against a reference model.
module tb_coklu_bitlik_seri_toplayici;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic b0, c0, h0, g0;
  logic [7:0] a0, bb0;
  logic [8:0] o0;
  logic b1, c1, h1, g1;
  logic [7:0] a1, bb1;
  logic [8:0] o1;
  logic b2, c2, h2, g2;
  logic [15:0] a2, bb2;
  logic [16:0] o2;
`ifdef SERI_TOPLAYICI_TASMA_EN
  logic t0, t1, t2;
`endif

  coklu_bitlik_seri_toplayici #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .Basla(b0), .Cikar(c0), .A(a0), .B(bb0),
    .Hazir(h0), .Gecerli(g0), .Cikis(o0)
`ifdef SERI_TOPLAYICI_TASMA_EN
    , .Tasma(t0)
`endif
  );

  coklu_bitlik_seri_toplayici #(.WIDTH(8), .DIGIT(2)) u_dut1 (
    .clk(clk), .rst(rst), .Basla(b1), .Cikar(c1), .A(a1), .B(bb1),
    .Hazir(h1), .Gecerli(g1), .Cikis(o1)
`ifdef SERI_TOPLAYICI_TASMA_EN
    , .Tasma(t1)
`endif
  );

  coklu_bitlik_seri_toplayici #(.WIDTH(16), .DIGIT(4)) u_dut2 (
    .clk(clk), .rst(rst), .Basla(b2), .Cikar(c2), .A(a2), .B(bb2),
    .Hazir(h2), .Gecerli(g2), .Cikis(o2)
`ifdef SERI_TOPLAYICI_TASMA_EN
    , .Tasma(t2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_g2  = -1;
  int g2_count = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [17:0] e0, e1, e2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {signed overflow, carry/no-borrow, w-bit sum}.
  function automatic logic [17:0] model(input int w, input logic sub,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [16:0] m, r;
    logic [15:0] bo;
    logic sa, sb, sr, ov;
    m  = (17'd1 << w) - 17'd1;
    bo = sub ? ~b : b;
    r  = ({1'b0, a} & m) + ({1'b0, bo} & m) + {16'd0, sub};
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, r};
  endfunction

  function automatic logic hz(input int sel);
    return (sel == 0) ? h0 : ((sel == 1) ? h1 : h2);
  endfunction

  function automatic logic gv(input int sel);
    return (sel == 0) ? g0 : ((sel == 1) ? g1 : g2);
  endfunction

  task automatic set_in(input int sel, input logic st, input logic sub,
                        input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin
      b0 = st; c0 = sub; a0 = a; bb0 = b;
    end else begin
      b1 = st; c1 = sub; a1 = a; bb1 = b;
    end
  endtask

  task automatic wait_ready(input int sel);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hz(sel)) break;
    end
    check_eq($sformatf("hazir_wait_%0d", sel), {31'd0, hz(sel)}, 32'd1);
  endtask

  // One 8-bit operation with cycle-exact Gecerli/Hazir checks; optional Basla glitch mid-compute.
  task automatic run8(input int sel, input logic sub, input logic [7:0] a,
                      input logic [7:0] b, input bit glitch);
    int n;
    n = (sel == 0) ? 8 : 4;
    wait_ready(sel);
    set_in(sel, 1'b1, sub, a, b);
    if (sel == 0) q0.push_back(model(8, sub, {8'd0, a}, {8'd0, b}));
    else          q1.push_back(model(8, sub, {8'd0, a}, {8'd0, b}));
    @(posedge clk); #1;
    set_in(sel, 1'b0, ~sub, ~a, ~b);
    check_eq($sformatf("hazir_busy_%0d", sel), {31'd0, hz(sel)}, 32'd0);
    for (int k = 1; k <= n; k++) begin
      if (glitch && k == 3) set_in(sel, 1'b1, ~sub, a ^ 8'h5A, b + 8'd3);
      if (glitch && k == 4) set_in(sel, 1'b0, sub, 8'h00, 8'h00);
      @(posedge clk); #1;
      check_eq($sformatf("gecerli_%0d_k%0d", sel, k), {31'd0, gv(sel)}, (k == n) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    check_eq($sformatf("gecerli_drop_%0d", sel), {31'd0, gv(sel)}, 32'd0);
    check_eq($sformatf("hazir_back_%0d", sel), {31'd0, hz(sel)}, 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard compare for each instance whenever it signals a result.
  always @(negedge clk) begin
    if (!rst && g0) begin
      if (q0.size() == 0) check_eq("dut0_unexpected_gecerli", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check_eq("dut0_cikis", {23'd0, o0}, {23'd0, e0[8:0]});
`ifdef SERI_TOPLAYICI_TASMA_EN
        check_eq("dut0_tasma", {31'd0, t0}, {31'd0, e0[17]});
`endif
      end
    end
    if (!rst && g1) begin
      if (q1.size() == 0) check_eq("dut1_unexpected_gecerli", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check_eq("dut1_cikis", {23'd0, o1}, {23'd0, e1[8:0]});
`ifdef SERI_TOPLAYICI_TASMA_EN
        check_eq("dut1_tasma", {31'd0, t1}, {31'd0, e1[17]});
`endif
      end
    end
    if (!rst && g2) begin
      g2_count++;
      if (last_g2 >= 0) check_eq("dut2_spacing", cyc - last_g2, 32'd6);
      last_g2 = cyc;
      if (q2.size() == 0) check_eq("dut2_unexpected_gecerli", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check_eq("dut2_cikis", {15'd0, o2}, {15'd0, e2[16:0]});
`ifdef SERI_TOPLAYICI_TASMA_EN
        check_eq("dut2_tasma", {31'd0, t2}, {31'd0, e2[17]});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    b0 = 1'b0; c0 = 1'b0; a0 = 8'd0; bb0 = 8'd0;
    b1 = 1'b0; c1 = 1'b0; a1 = 8'd0; bb1 = 8'd0;
    b2 = 1'b0; c2 = 1'b0; a2 = 16'd0; bb2 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hazir0", {31'd0, h0}, 32'd1);
    check_eq("rst_gecerli0", {31'd0, g0}, 32'd0);
    check_eq("rst_cikis0", {23'd0, o0}, 32'd0);
    check_eq("rst_cikis2", {15'd0, o2}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    run8(0, 1'b0, 8'd200, 8'd100, 1'b0);
    run8(1, 1'b0, 8'hFF, 8'h01, 1'b0);
    run8(1, 1'b1, 8'd5, 8'd9, 1'b0);
    run8(1, 1'b1, 8'h10, 8'h10, 1'b0);
    run8(0, 1'b0, 8'h37, 8'h21, 1'b1);
    run8(0, 1'b0, 8'd100, 8'd100, 1'b0);
    run8(0, 1'b1, 8'h80, 8'h01, 1'b0);
    run8(0, 1'b0, 8'd50, 8'd20, 1'b0);
    repeat (12) @(negedge clk);

    // Abort an add at compute cycle 3 with reset.
    wait_ready(0);
    set_in(0, 1'b1, 1'b0, 8'h55, 8'h66);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_cikis0", {23'd0, o0}, 32'd0);
    check_eq("abort_gecerli0", {31'd0, g0}, 32'd0);
    check_eq("abort_hazir0", {31'd0, h0}, 32'd1);
    check_eq("abort_cikis1", {23'd0, o1}, 32'd0);
`ifdef SERI_TOPLAYICI_TASMA_EN
    check_eq("abort_tasma0", {31'd0, t0}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    run8(0, 1'b0, 8'd1, 8'd1, 1'b0);

    // Back-to-back stream on the 16/4 instance with Basla held high.
    for (int i = 0; i < 8; i++) begin
      wait_ready(2);
      a2  = 16'($urandom);
      bb2 = 16'($urandom);
      c2  = 1'($urandom_range(0, 1));
      b2  = 1'b1;
      q2.push_back(model(16, c2, a2, bb2));
      @(posedge clk); #1;
      a2 = 16'($urandom);
      bb2 = 16'($urandom);
    end
    b2 = 1'b0;
    for (int i = 0; i < 100 && q2.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check_eq("dut2_drain", q2.size(), 32'd0);
    check_eq("dut2_count", g2_count, 32'd8);
    check_eq("dut0_drain", q0.size(), 32'd0);
    check_eq("dut1_drain", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
